// File: rtl/accumulator_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine.
// Owns PC, IR and ACC; drives main memory and the external ALU.
module accumulator_control_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [15:0]           mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [15:0]           mem_rdata,
    output logic [3:0]            alu_op,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    input  logic [15:0]           alu_result,
    output logic [15:0]           acc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           ir,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;
    localparam logic [3:0] OP_SHR   = 4'hB;
    localparam logic [3:0] OP_LOADI = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state;

    logic [3:0]            opc;
    logic [ADDR_WIDTH-1:0] target;

    assign opc    = ir[15:12];
    assign target = ir[ADDR_WIDTH-1:0];

    // Operand address only in MEM; every other state points at pc.
    assign mem_addr  = (state == S_MEM) ? {4'h0, ir[11:0]} : 16'(pc);
    assign mem_wdata = acc;
    assign alu_a     = acc;
    assign alu_b     = mem_rdata;

    always_comb begin
        alu_op = 4'b0000;
        unique case (opc)
            OP_SUB:  alu_op = 4'b0001;
            OP_SHL:  alu_op = 4'b0100;
            OP_SHR:  alu_op = 4'b0101;
            OP_AND:  alu_op = 4'b1000;
            OP_OR:   alu_op = 4'b1001;
            OP_XOR:  alu_op = 4'b1010;
            default: alu_op = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            acc    <= 16'h0000;
            ir     <= 16'h0000;
            pc     <= PC_RST;
            mem_we <= 1'b0;
            halted <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 1'b1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= S_FETCH;
                    unique case (opc)
                        OP_JUMP: pc <= target;
                        OP_JZ: begin
                            if (acc == 16'h0000) pc <= target;
                        end
                        OP_SHL, OP_SHR: acc <= alu_result;
                        OP_LOADI: acc <= {4'h0, ir[11:0]};
                        OP_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        OP_STORE: begin
                            state  <= S_MEM;
                            mem_we <= 1'b1;
                        end
                        OP_LOAD, OP_ADD, OP_SUB,
                        OP_AND, OP_OR, OP_XOR: state <= S_MEM;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEM: state <= (opc == OP_STORE) ? S_FETCH : S_WB;
                S_WB: begin
                    acc   <= (opc == OP_LOAD) ? mem_rdata : alu_result;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Bench for accumulator_control_unit with a registered-read memory
// and a combinational ALU; halt results and writes are scoreboarded.
module tb_accumulator_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [15:0] acc;
    logic [11:0] pc;
    logic [15:0] ir;
    logic        halted;

    accumulator_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .acc        (acc),
        .pc         (pc),
        .ir         (ir),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:0]];
    end

    function automatic logic [15:0] alu_f(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return {a[14:0], 1'b0};
            4'b0101: return {1'b0, a[15:1]};
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    typedef struct {
        logic [15:0] acc;
        logic [11:0] pc;
        int          cyc;
        logic [3:0]  op;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wr_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int we_cnt;
    bit wr_chk;
    bit halt_seen;
    logic [15:0] prev_acc;
    logic [3:0]  op_prev;
    logic [3:0]  last_op;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // Monitor: acc-change op tracking, write scoreboard, halt scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            halt_seen = 1'b0;
            prev_acc  = 16'h0000;
            op_prev   = 4'h0;
            last_op   = 4'h0;
        end else begin
            if (acc != prev_acc) last_op = op_prev;
            prev_acc = acc;
            op_prev  = alu_op;
            if (mem_we && wr_chk) begin
                we_cnt++;
                if (wr_q.size() == 0) chk("wr_expected", wr_q.size(), 1);
                else chk("wr", {mem_addr, mem_wdata}, wr_q.pop_front());
            end
            if (halted && !halt_seen) begin
                halt_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("halt_expected", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("halt_acc", acc, e.acc);
                    chk("halt_pc", pc, e.pc);
                    chk("halt_cyc", cyc, e.cyc);
                    chk("halt_op", last_op, e.op);
                    chk("halt_addr", mem_addr, {4'h0, e.pc});
                end
            end
        end
    end

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_we = 1'b0;
    endtask

    task automatic begin_load();
        reset  = 1'b1;
        we_cnt = 0;
        wr_chk = 1'b1;
        for (int a = 0; a < 64; a++) poke(12'(a), 16'h0000);
        poke(12'hFFF, 16'h0000);
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [11:0] p,
                            input int c, input logic [3:0] o);
        exp_t e;
        e.acc = a;
        e.pc  = p;
        e.cyc = c;
        e.op  = o;
        exp_q.push_back(e);
    endtask

    task automatic go();
        @(negedge clk);
        chk("rst_acc", acc, 16'h0000);
        chk("rst_pc", pc, 12'h000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("fetch0_addr", mem_addr, 16'h0000);
    endtask

    task automatic wait_cyc(input int k);
        for (int i = 0; i < 50 && cyc != k; i++) @(negedge clk);
        chk("cyc_reach", cyc, k);
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 300 && !halt_seen; i++) @(negedge clk);
        chk("halt_seen", halt_seen, 1'b1);
        if (!halt_seen && exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        chk("wr_left", wr_q.size(), 0);
        wr_q.delete();
    endtask

    task automatic alu_prog(input logic [15:0] i0, input logic [15:0] i1,
                            input logic [15:0] d30, input logic [15:0] d31);
        begin_load();
        poke(12'h000, i0);
        poke(12'h001, i1);
        poke(12'h002, 16'hF000);
        poke(12'h030, d30);
        poke(12'h031, d31);
        go();
        wait_halt();
    endtask

    initial begin
        bit ok;
        reset   = 1'b1;
        ld_we   = 1'b0;
        ld_addr = 12'h000;
        ld_data = 16'h0000;
        wr_chk  = 1'b1;
        we_cnt  = 0;
        repeat (2) @(posedge clk);

        begin_load();
        poke(12'h000, 16'h1010);
        poke(12'h001, 16'h3011);
        poke(12'h002, 16'h2012);
        poke(12'h003, 16'hF000);
        poke(12'h010, 16'h0005);
        poke(12'h011, 16'h0003);
        wr_q.push_back({16'h0012, 16'h0008});
        push_exp(16'h0008, 12'h004, 17, 4'b0000);
        go();
        wait_halt();
        chk("prog_mem12", mem[12'h012], 16'h0008);
        chk("prog_we_cnt", we_cnt, 1);

        begin_load();
        poke(12'h000, 16'hC000);
        poke(12'h001, 16'h9020);
        poke(12'h020, 16'hF000);
        push_exp(16'h0000, 12'h021, 9, 4'b0000);
        go();
        wait_cyc(6);
        chk("jz_taken_fetch", mem_addr, 16'h0020);
        wait_halt();

        begin_load();
        poke(12'h000, 16'hC001);
        poke(12'h001, 16'h9020);
        poke(12'h002, 16'hF000);
        poke(12'h020, 16'hF000);
        push_exp(16'h0001, 12'h003, 9, 4'b0000);
        go();
        wait_cyc(6);
        chk("jz_fall_fetch", mem_addr, 16'h0002);
        wait_halt();

        push_exp(16'hF100, 12'h003, 11, 4'b0001);
        alu_prog(16'hC0F0, 16'h4030, 16'h0FF0, 16'h0000);
        push_exp(16'h0F00, 12'h003, 11, 4'b1010);
        alu_prog(16'hC0F0, 16'h7030, 16'h0FF0, 16'h0000);
        push_exp(16'h0002, 12'h003, 11, 4'b0100);
        alu_prog(16'h1031, 16'hA000, 16'h0000, 16'h8001);
        push_exp(16'h4000, 12'h003, 11, 4'b0101);
        alu_prog(16'h1031, 16'hB000, 16'h0000, 16'h8001);

        begin_load();
        poke(12'h000, 16'hC0F0);
        poke(12'h001, 16'hD123);
        poke(12'h002, 16'hE456);
        poke(12'h003, 16'hF000);
        push_exp(16'h00F0, 12'h004, 12, 4'b0000);
        go();
        wait_halt();

        begin_load();
        poke(12'h000, 16'h8FFF);
        go();
        wait_cyc(3);
        chk("wrap_fetch_fff", mem_addr, 16'h0FFF);
        wait_cyc(5);
        chk("wrap_pc", pc, 12'h000);
        wait_cyc(6);
        chk("wrap_fetch_0", mem_addr, 16'h0000);

        begin_load();
        wr_chk = 1'b0;
        poke(12'h000, 16'hC123);
        poke(12'h001, 16'h2012);
        poke(12'h012, 16'h5A5A);
        go();
        wait_cyc(6);
        chk("st_we_pre", mem_we, 1'b1);
        chk("st_addr_pre", mem_addr, 16'h0012);
        #1 reset = 1'b1;
        #1;
        chk("st_we_rst", mem_we, 1'b0);
        chk("st_acc_rst", acc, 16'h0000);
        chk("st_pc_rst", pc, 12'h000);
        chk("st_addr_rst", mem_addr, 16'h0000);
        @(posedge clk);
        #1;
        ok = (mem[12'h012] == 16'h5A5A) || (mem[12'h012] == 16'h0123);
        chk("st_mem_intact", ok, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
